// File: rtl/bus_init_pkg.sv
// Shared types for the ack/id bus initiator: FSM states and the rolling transaction id.
package bus_init_pkg;

    localparam int TID_W = 4;

    typedef logic [TID_W-1:0] tid_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP,
        RELEASE
    } state_t;

    // Reads are matched on rid, writes on wid; the other channel is don't-care.
    function automatic logic id_match(input logic we, input tid_t rid, input tid_t wid,
                                      input tid_t tid);
        return we ? (wid == tid) : (rid == tid);
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle-abort counter for the bus initiator: counts ce-qualified clocks while en is high
// and flags the clock on which the TIMEOUT-th count would land.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ce_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (ce_i) begin
            if (clr) begin
                cnt_reg <= '0;
            end else if (en) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Combinational so the abort takes effect on the same edge the count reaches TIMEOUT.
    assign expired = en && (cnt_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_initiator.sv
// Initiator end of the ack/id bus: one host request at a time, id-matched ack, response hold.
// Optional cycle abort on missing ack is built when BUS_TIMEOUT_EN is defined.
module bus_initiator
    import bus_init_pkg::*;
#(
    parameter int   AWID      = 32,
    parameter int   DWID      = 32,
    parameter int   TIMEOUT   = 255,
    parameter logic ACK_LEVEL = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ce_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AWID-1:0]   req_adr_i,
    input  logic [DWID-1:0]   req_dat_i,
    input  logic [DWID/8-1:0] req_sel_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [AWID-1:0]   adr_o,
    output logic [DWID-1:0]   dat_o,
    output logic [DWID/8-1:0] sel_o,
    output logic [3:0]        rid_o,
    output logic [3:0]        wid_o,
    input  logic              ack_i,
    input  logic [3:0]        rid_i,
    input  logic [3:0]        wid_i,
    input  logic [DWID-1:0]   dat_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_we_o,
    output logic [DWID-1:0]   rsp_dat_o,
    output logic              rsp_err_o
);

    localparam int SW = DWID / 8;

    state_t            state_reg;
    tid_t              tid_reg;
    logic              req_ready_reg;
    logic              cyc_reg;
    logic              stb_reg;
    logic              we_reg;
    logic [AWID-1:0]   adr_reg;
    logic [DWID-1:0]   dat_reg;
    logic [SW-1:0]     sel_reg;
    tid_t              rid_reg;
    tid_t              wid_reg;
    logic              rsp_valid_reg;
    logic              rsp_we_reg;
    logic [DWID-1:0]   rsp_dat_reg;
    logic              rsp_err_reg;

    logic accept;
    logic ack_ok;
    logic to_expired;

    assign accept = (state_reg == IDLE) && req_ready_reg && req_valid_i;
    assign ack_ok = ack_i && id_match(we_reg, rid_i, wid_i, tid_reg);

`ifdef BUS_TIMEOUT_EN
    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .ce_i    (ce_i),
        .clr     (accept),
        .en      (state_reg == ACTIVE),
        .expired (to_expired)
    );
`else
    // Without the counter an ACTIVE cycle waits for its ack indefinitely.
    assign to_expired = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            tid_reg       <= '0;
            req_ready_reg <= 1'b0;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            adr_reg       <= '0;
            dat_reg       <= '0;
            sel_reg       <= '0;
            rid_reg       <= '0;
            wid_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_we_reg    <= 1'b0;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (ce_i) begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        cyc_reg       <= 1'b1;
                        stb_reg       <= 1'b1;
                        we_reg        <= req_we_i;
                        adr_reg       <= req_adr_i;
                        dat_reg       <= req_dat_i;
                        sel_reg       <= req_sel_i;
                        rid_reg       <= req_we_i ? '0 : tid_reg;
                        wid_reg       <= req_we_i ? tid_reg : '0;
                        state_reg     <= ACTIVE;
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // A matching ack on the expiry clock still completes normally.
                    if (ack_ok || to_expired) begin
                        cyc_reg       <= 1'b0;
                        stb_reg       <= 1'b0;
                        we_reg        <= 1'b0;
                        adr_reg       <= '0;
                        dat_reg       <= '0;
                        sel_reg       <= '0;
                        rid_reg       <= '0;
                        wid_reg       <= '0;
                        rsp_valid_reg <= 1'b1;
                        rsp_we_reg    <= we_reg;
                        rsp_dat_reg   <= (ack_ok && !we_reg) ? dat_i : '0;
                        rsp_err_reg   <= !ack_ok;
                        tid_reg       <= tid_reg + 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_we_reg    <= 1'b0;
                        rsp_dat_reg   <= '0;
                        rsp_err_reg   <= 1'b0;
                        if (ack_i != ACK_LEVEL) begin
                            state_reg <= RELEASE;
                        end else begin
                            req_ready_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                end
                RELEASE: begin
                    // Registered responders hold ack one clock past stb; do not overlap cycles.
                    if (ack_i == ACK_LEVEL) begin
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_reg;
    assign cyc_o       = cyc_reg;
    assign stb_o       = stb_reg;
    assign we_o        = we_reg;
    assign adr_o       = adr_reg;
    assign dat_o       = dat_reg;
    assign sel_o       = sel_reg;
    assign rid_o       = rid_reg;
    assign wid_o       = wid_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_we_o    = rsp_we_reg;
    assign rsp_dat_o   = rsp_dat_reg;
    assign rsp_err_o   = rsp_err_reg;

endmodule
